vector_lane_sequencer: RTL
==========================

# vector_lane_sequencer

Multi-beat vector execute unit for the EX stage. It accepts one V-element vector operation, either vector-vector or vector-scalar. It streams the operation through L parallel lane ALUs over ceil(V/L) beats, reassembles the V-element result, and raises a one-cycle done pulse. It is the parametrised successor of the fixed 4-lane fork/ALU/join datapath, adding a start/ready handshake, stall, partial-beat masking and result flags; it sits between the ID/EX and EX/MEM pipeline registers.

## Interface
- N, 32, element width in bits
- V, 20, elements per vector (V ≥ 1)
- L, 4, lane ALU count (1 ≤ L ≤ V)
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- start_i  in  1  request; accepted on an edge where start_i && ready_o
- op_type_i  in  2  01 vector-vector, 10 vector-scalar; 00/11 reserved, executed as vector-vector
- alu_ctrl_i  in  2  00 add, 01 sub, 10 and, 11 or
- vec_a_i  in  V×N  operand A, packed [V-1:0][N-1:0]
- vec_b_i  in  V×N  operand B (ignored for vector-scalar)
- scalar_i  in  N  broadcast B operand for vector-scalar
- stall_i  in  1  freezes beat progress while high
- ready_o  out  1  high only in IDLE
- busy_o  out  1  high in RUN or DONE
- done_o  out  1  one-cycle completion pulse
- result_o  out  V×N  assembled result; held until the next accept
- carry_o  out  1  OR of carry-outs of all active lanes over all beats (add/sub only, else 0)
- zero_o  out  1  all V result elements equal zero
- beat_o  out  $clog2(B) min 1  current beat index, for debug

## Operation
- B = ceil(V/L) beats. Beat k covers elements k·L … k·L+L-1; lanes with index ≥ V are inactive. Inactive lanes write nothing and contribute no carry.
- States:
  - IDLE: ready_o=1. On accept, latch A, B/scalar, op_type and alu_ctrl into operand registers. Clear result_o, carry_o and beat, then go to RUN.
  - RUN: lanes compute from the latched operands at the current beat. On each edge with stall_i=0, write the active results into result_o, OR in the carries, and increment beat. On the edge that writes beat B-1, go to DONE.
  - RUN with stall_i=1: hold everything.
  - DONE: done_o=1 for exactly one cycle, then IDLE. stall_i has no effect in DONE.
- Lane B operand: vec_b[k·L+j] for vector-vector, scalar_i for vector-scalar.
- Arithmetic: add and sub wrap modulo 2^N. Sub is computed as A + ~B + 1, and its carry is that adder's carry-out. For and/or the carry is 0.
- zero_o is combinational from result_o, and is qualified only when done_o=1 or in IDLE after a completion.
- start_i while busy is ignored; inputs changing during RUN have no effect.

## Timing
- Reset (asynchronous, any state): state IDLE, ready_o=1, busy_o=0, done_o=0, result_o=0, carry_o=0, beat_o=0, operand registers 0.
- Reset mid-operation discards the operation with no done_o.
- With the accept edge as e0 and no stall:
  - beats are written at edges e1…eB;
  - done_o is high between eB and eB+1;
  - ready_o returns at eB+1.
- Total latency is B+1 cycles accept-to-ready. For V=20, L=4 that is 5 beats, done_o after e5, ready after e6.
- Each stalled RUN cycle adds exactly one cycle to latency.
- result_o is stable from the done_o cycle until the next accept edge.
- There is no combinational path from start_i to any output.

## Structure
- Package vec_pkg holds:
  - op_type_e (VV=2'b01, VS=2'b10);
  - alu_ctrl_e (ADD, SUB, AND, OR);
  - seq_state_e (IDLE, RUN, DONE);
  - function num_beats(V,L).
- Sub-module vec_lane_alu: combinational, N-bit, ports a, b, ctrl, result, carry. It is instantiated L times in a generate loop.
- The top level holds the FSM, beat counter, operand registers, lane mux/masking and result write-back.

## Test plan
- VV add, N=32 V=20 L=4, A[i]=i, B[i]=2i -> result[i]=3i, done_o after e5, carry_o=0, zero_o=0.
- VS sub, scalar_i=3, A[i]=i -> result[0]=32'hFFFFFFFD, result[19]=16, carry_o=1 (from i≥3).
- Partial beat, V=10 L=4 -> B=3; VV or with A[i]=i, B[i]=8 -> result[i]=i|8; elements 10/11 nonexistent, no out-of-range write; done after e3.
- stall_i high for 3 cycles during beat 2 -> beat_o frozen at 2, done_o delayed to after e8, result identical to the unstalled run.
- RST_N low during beat 3, plus start_i pulsed during RUN -> the pulse is ignored; the reset immediately gives result_o=0, ready_o=1 with no done_o; a following VV and with B=0 gives zero_o=1 at done.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types and helpers for the vector lane sequencer.
package vec_pkg;

  typedef enum logic [1:0] {
    VV = 2'b01,
    VS = 2'b10
  } op_type_e;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } seq_state_e;

  // Beats needed to cover v elements with l lanes (ceil(v/l)).
  function automatic int num_beats(input int v, input int l);
    return (v + l - 1) / l;
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// One combinational N-bit lane ALU: add, sub (A + ~B + 1), and, or.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  alu_ctrl_e    ctrl,
  output logic [N-1:0] result,
  output logic         carry
);

  logic [N:0] w_sum;

  // Select the operation; carry is the adder carry-out for add/sub only.
  always_comb begin
    w_sum  = '0;
    result = '0;
    carry  = 1'b0;
    case (ctrl)
      ADD: begin
        w_sum  = {1'b0, a} + {1'b0, b};
        result = w_sum[N-1:0];
        carry  = w_sum[N];
      end
      SUB: begin
        w_sum  = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
        result = w_sum[N-1:0];
        carry  = w_sum[N];
      end
      AND:     result = a & b;
      OR:      result = a | b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/vector_lane_sequencer.sv
// Multi-beat vector execute unit: streams V elements through L lane ALUs
// over ceil(V/L) beats and reassembles the result.
module vector_lane_sequencer
  import vec_pkg::*;
#(
  parameter  int N  = 32,
  parameter  int V  = 20,
  parameter  int L  = 4,
  localparam int B  = num_beats(V, L),
  localparam int BW = (B > 1) ? $clog2(B) : 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start_i,
  input  logic [1:0]          op_type_i,
  input  logic [1:0]          alu_ctrl_i,
  input  logic [V-1:0][N-1:0] vec_a_i,
  input  logic [V-1:0][N-1:0] vec_b_i,
  input  logic [N-1:0]        scalar_i,
  input  logic                stall_i,
  output logic                ready_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [V-1:0][N-1:0] result_o,
  output logic                carry_o,
  output logic                zero_o,
  output logic [BW-1:0]       beat_o
);

  seq_state_e          r_state, w_next;
  logic [V-1:0][N-1:0] r_a, r_b;
  alu_ctrl_e           r_ctrl;
  logic [BW-1:0]       r_beat;
  logic                r_carry;

  logic                w_accept, w_advance, w_last;
  logic [L-1:0][N-1:0] w_lres;
  logic [L-1:0]        w_lcarry, w_lact;

  assign w_accept  = (r_state == IDLE) && start_i;
  assign w_advance = (r_state == RUN) && !stall_i;
  assign w_last    = (r_beat == BW'(B - 1));

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: DONE lasts one cycle and ignores stall.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start_i) w_next = RUN;
      RUN:     if (w_advance && w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Status outputs decoded from state only, so start_i never reaches them.
  always_comb begin
    ready_o = (r_state == IDLE);
    busy_o  = (r_state == RUN) || (r_state == DONE);
    done_o  = (r_state == DONE);
  end

  // Operand capture on accept; vector-scalar broadcasts the scalar into B.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_a    <= '0;
      r_b    <= '0;
      r_ctrl <= ADD;
    end else if (w_accept) begin
      r_a    <= vec_a_i;
      r_b    <= (op_type_i == VS) ? {V{scalar_i}} : vec_b_i;
      r_ctrl <= alu_ctrl_e'(alu_ctrl_i);
    end
  end

  // Beat counter and sticky carry; both frozen while stalled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_beat  <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_beat  <= '0;
      r_carry <= 1'b0;
    end else if (w_advance) begin
      r_carry <= r_carry | (|(w_lcarry & w_lact));
      if (!w_last) r_beat <= r_beat + BW'(1);
    end
  end

  // Lane operand mux: lane j at beat k sees element k*L+j, or is inactive.
  for (genvar j = 0; j < L; j++) begin : g_lane
    logic [B-1:0][N-1:0] w_a_cand, w_b_cand;
    logic [B-1:0]        w_act_cand;
    logic [N-1:0]        w_a, w_b;

    for (genvar k = 0; k < B; k++) begin : g_beat
      if (k * L + j < V) begin : g_on
        assign w_a_cand[k]   = r_a[k*L+j];
        assign w_b_cand[k]   = r_b[k*L+j];
        assign w_act_cand[k] = 1'b1;
      end else begin : g_off
        assign w_a_cand[k]   = '0;
        assign w_b_cand[k]   = '0;
        assign w_act_cand[k] = 1'b0;
      end
    end

    assign w_a       = w_a_cand[r_beat];
    assign w_b       = w_b_cand[r_beat];
    assign w_lact[j] = w_act_cand[r_beat];

    vec_lane_alu #(.N(N)) u_alu (
      .a      (w_a),
      .b      (w_b),
      .ctrl   (r_ctrl),
      .result (w_lres[j]),
      .carry  (w_lcarry[j])
    );
  end

  // Result write-back: each element is owned by exactly one (beat, lane).
  for (genvar i = 0; i < V; i++) begin : g_elem
    logic [N-1:0] r_elem;

    // Clear on accept, capture the owning lane on its beat.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                                     r_elem <= '0;
      else if (w_accept)                              r_elem <= '0;
      else if (w_advance && (r_beat == BW'(i / L)))   r_elem <= w_lres[i % L];
    end

    assign result_o[i] = r_elem;
  end

  assign carry_o = r_carry;
  assign beat_o  = r_beat;
  assign zero_o  = (result_o == '0);

endmodule
